// File: rtl/hdlc_rx_arbiter_pkg.sv
// Shared types and helpers for the HDLC receive-side frame arbiter.
package hdlc_rx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_XFER  = 2'd2
  } state_e;

  localparam int unsigned MAX_N    = 16;
  localparam int unsigned MAX_CH_W = 4;

  // Round-robin pick over the first n requesters, starting after last; returns {any, idx}.
  function automatic logic [MAX_CH_W:0] next_after(input logic [MAX_N-1:0]    req,
                                                   input logic [MAX_CH_W-1:0] last,
                                                   input int unsigned         n);
    logic [MAX_CH_W:0] res;
    int unsigned       c;
    res = '0;
    for (int unsigned k = 1; k <= n; k++) begin
      c = (32'(last) + k) % n;
      if (!res[MAX_CH_W] && req[c]) res = {1'b1, MAX_CH_W'(c)};
    end
    return res;
  endfunction

endpackage

// File: rtl/hdlc_rx_arbiter_if.sv
// Tagged byte stream from the arbiter to the single host/DMA consumer.
interface hdlc_rx_arbiter_if #(
  parameter int unsigned CH_W  = 2,
  parameter int unsigned LEN_W = 16
) ();

  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_first;
  logic             out_last;
  logic [CH_W-1:0]  out_ch;
  logic [LEN_W-1:0] out_len;

  modport master (
    output out_data, out_valid, out_first, out_last, out_ch, out_len,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, out_first, out_last, out_ch, out_len,
    output out_ready
  );

endinterface

// File: rtl/hdlc_rx_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate requests past last, priority-encode, rotate back.
module hdlc_rx_arbiter_rr_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned CH_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [CH_W-1:0] last,
  output logic            any,
  output logic [CH_W-1:0] idx
);

  int unsigned     base;
  logic [N-1:0]    rot;
  logic [CH_W-1:0] off;

  assign base = (32'(last) + 32'd1) % N;
  // rot[0] is the requester with highest priority (the one right after last).
  assign rot  = N'({req, req} >> base);

  always_comb begin
    off = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (rot[i]) off = CH_W'(i);
    end
  end

  assign any = |req;
  assign idx = CH_W'((base + 32'(off)) % N);

endmodule

// File: rtl/hdlc_rx_arbiter.sv
// Frame-granular round-robin drain of N HDLC receive FIFOs into one tagged byte stream.
module hdlc_rx_arbiter
  import hdlc_rx_arbiter_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned CH_W  = 2,
  parameter int unsigned LEN_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N-1:0]        enable,
  input  logic [N*8-1:0]      ch_data,
  input  logic [N-1:0]        ch_empty,
  input  logic [N-1:0]        ch_eof,
  output logic [N-1:0]        ch_start,
  output logic [N-1:0]        ch_get,
  hdlc_rx_arbiter_if.master   stream,
  output logic                busy
);

  state_e           state_q;
  logic [CH_W-1:0]  grant_q;
  logic [CH_W-1:0]  last_grant_q;
  logic             first_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_next;

  logic             pick_any;
  logic [CH_W-1:0]  pick_idx;
  logic             head_empty;
  logic             head_eof;
  logic [7:0]       head_data;
  logic             cap;

  hdlc_rx_arbiter_rr_pick #(
    .N    (N),
    .CH_W (CH_W)
  ) u_rr_pick (
    .req  (enable & ~ch_empty),
    .last (last_grant_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  assign head_empty = ch_empty[grant_q];
  assign head_eof   = ch_eof[grant_q];
  assign head_data  = ch_data[8*32'(grant_q) +: 8];

  // A byte moves whenever the granted FIFO has one and the output register is free or draining.
  assign cap      = (state_q == ST_XFER) && !head_empty &&
                    (!stream.out_valid || stream.out_ready);
  assign len_next = (len_q == '1) ? len_q : len_q + 1'b1;
  assign ch_get   = cap ? (N'(1) << grant_q) : '0;
  assign busy     = (state_q != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      grant_q          <= '0;
      last_grant_q     <= CH_W'(N - 1);
      first_q          <= 1'b0;
      len_q            <= '0;
      ch_start         <= '0;
      stream.out_data  <= '0;
      stream.out_valid <= 1'b0;
      stream.out_first <= 1'b0;
      stream.out_last  <= 1'b0;
      stream.out_ch    <= '0;
      stream.out_len   <= '0;
    end else begin
      ch_start <= '0;

      if (cap) begin
        stream.out_data  <= head_data;
        stream.out_valid <= 1'b1;
        stream.out_ch    <= grant_q;
        stream.out_first <= first_q;
        stream.out_last  <= head_eof;
        stream.out_len   <= len_next;
        first_q          <= 1'b0;
        len_q            <= len_next;
      end else if (stream.out_ready) begin
        stream.out_valid <= 1'b0;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            grant_q  <= pick_idx;
            ch_start <= N'(1) << pick_idx;
            state_q  <= ST_START;
          end
        end
        ST_START: begin
          len_q   <= '0;
          first_q <= 1'b1;
          state_q <= ST_XFER;
        end
        ST_XFER: begin
          if (cap && head_eof) begin
            last_grant_q <= grant_q;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
